// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access state machine
// encoding and the default geometry/latency of the memory.
package dmem_pkg;

    localparam int DMEM_WORD_W  = 32;
    localparam int DMEM_DEPTH   = 256;
    localparam int DMEM_LATENCY = 3;
    localparam int DMEM_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide single-port storage for the data-memory responder.
// Writes and reads happen on the clock edge; the read result is held in
// a register until the next read. A synchronous clear zeroes every word
// and the read register.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   we,
    input  logic                   re,
    input  logic [IDX_W-1:0]       idx,
    input  logic [DMEM_WORD_W-1:0] wdata,
    output logic [DMEM_WORD_W-1:0] rdata
);

    logic [DMEM_WORD_W-1:0] mem [DEPTH];

    // Storage update, registered read and whole-array clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[idx] <= wdata;
            end
            if (re) begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for an in-order pipeline.
// A request seen in IDLE stalls the pipeline for LATENCY+1 cycles, the
// access happens on the last BUSY edge, and DONE pulses ack while the
// pipeline is released. Optional misalignment checking is enabled by
// defining DMEM_ALIGN_CHECK_EN; without it addr[1:0] is ignored and err
// is tied low.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        ack,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q;

    logic             req;
    logic             accept;
    logic             fire;
    logic [IDX_W-1:0] idx_p0;
    logic [31:0]      wdata_p0;
    logic             wr_p0;
    logic             mis_p0;
    logic             unused_addr_bits;

    assign req    = mem_read | mem_write;
    assign accept = (state_q == IDLE) && req && !rst;
    assign fire   = (state_q == BUSY) && (cnt_q == '0) && !rst;

    // Upper address bits wrap by design; the byte offset only matters for the check.
    assign unused_addr_bits = &{1'b0, addr[31:IDX_W+2], addr[1:0]};

    // State register and BUSY down-counter; reset aborts any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Next state plus stall/ack; DONE ignores the still-present request.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    stall   = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // ---- request capture (p0): operands held for the whole access ----
    // Capture the request on acceptance; write wins over a simultaneous read.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0   <= addr[IDX_W+1:2];
            wdata_p0 <= wdata;
            wr_p0    <= mem_write;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Remember whether the accepted access was misaligned.
    always_ff @(posedge clk) begin
        if (accept) begin
            mis_p0 <= (addr[1:0] != 2'b00);
        end
    end

    assign err = ack & mis_p0;
`else
    assign mis_p0 = 1'b0;
    assign err    = 1'b0;
`endif

    // ---- access (p1): storage touched on the BUSY->DONE edge ----
    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .clear (rst),
        .we    (fire & wr_p0 & ~mis_p0),
        .re    (fire & ~wr_p0 & ~mis_p0),
        .idx   (idx_p0),
        .wdata (wdata_p0),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=256, LATENCY=3).
// A transaction-level model predicts stall/ack/err/rdata every cycle;
// directed accesses additionally pin literal results.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr      = '0;
    logic [31:0] wdata     = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        ack;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int ack_total = 0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .ack       (ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m = edges since the request was accepted (0 = no access in flight).
    int          m = 0;
    bit          ready = 1'b0;
    logic [31:0] mm [DEPTH];
    logic [31:0] m_rdata = '0;
    logic        m_wr = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_wd = '0;
    logic        m_mis = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m = 0;
            for (int i = 0; i < DEPTH; i++) mm[i] = '0;
            m_rdata = '0;
            ready = 1'b1;
        end else if (ready) begin
            if (m == 0) begin
                if (mem_read || mem_write) begin
                    m_wr  = mem_write;
                    m_idx = int'((addr >> 2) % DEPTH);
                    m_wd  = wdata;
                    m_mis = ALIGN && (addr[1:0] != 2'b00);
                    m = 1;
                end
            end else if (m <= LAT) begin
                if (m == LAT && !m_mis) begin
                    if (m_wr) mm[m_idx] = m_wd;
                    else      m_rdata   = mm[m_idx];
                end
                m++;
            end else begin
                m = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic e_stall, e_ack, e_err;
        if (ready) begin
            e_stall = 1'b0; e_ack = 1'b0; e_err = 1'b0;
            if (rst)            e_stall = 1'b0;
            else if (m == 0)    e_stall = mem_read | mem_write;
            else if (m <= LAT)  e_stall = 1'b1;
            else begin
                e_ack = 1'b1;
                e_err = m_mis;
            end
            chk("model_stall", {31'b0, stall}, {31'b0, e_stall});
            if (!rst) begin
                chk("model_ack", {31'b0, ack}, {31'b0, e_ack});
                chk("model_err", {31'b0, err}, {31'b0, e_err});
            end
            chk("model_rdata", rdata, m_rdata);
        end
        if (ack === 1'b1) ack_total++;
    end

    // ---------------- directed helpers ----------------
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdv,
                          output int nstall, output logic errv);
        bit found;
        found = 1'b0; nstall = 0; rdv = '0; errv = 1'b0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (ack) begin
                found = 1'b1; rdv = rdata; errv = err;
            end
        end
        if (!found) chk("access_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        int          ns;
        logic        ev;
        int          acks, first, second, snap;
        logic [31:0] rd2;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_ack",   {31'b0, ack},   32'd0);
        chk("rst_err",   {31'b0, err},   32'd0);

        // Write then read
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rv, ns, ev);
        chk("wr10_stall_cycles", ns, 32'd4);
        access(1'b1, 1'b0, 32'h10, 32'h0, rv, ns, ev);
        chk("rd10_data", rv, 32'hDEADBEEF);
        chk("rd10_stall_cycles", ns, 32'd4);

        // Address wrap
        access(1'b0, 1'b1, 32'h408, 32'h12345678, rv, ns, ev);
        access(1'b1, 1'b0, 32'h8, 32'h0, rv, ns, ev);
        chk("wrap_data", rv, 32'h12345678);

        // Simultaneous read+write: write wins, rdata untouched
        access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, rv, ns, ev);
        chk("both_rdata_kept", rv, 32'h12345678);
        access(1'b1, 1'b0, 32'h20, 32'h0, rv, ns, ev);
        chk("both_readback", rv, 32'hA5A5A5A5);

        // Idle cycles
        repeat (3) @(negedge clk);
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_ack",   {31'b0, ack},   32'd0);

        // Misaligned write to 0x13
        access(1'b0, 1'b1, 32'h13, 32'hCAFEF00D, rv, ns, ev);
        chk("mis_stall_cycles", ns, 32'd4);
        chk("mis_err", {31'b0, ev}, ALIGN ? 32'd1 : 32'd0);
        access(1'b1, 1'b0, 32'h10, 32'h0, rv, ns, ev);
        chk("mis_readback", rv, ALIGN ? 32'hDEADBEEF : 32'hCAFEF00D);
        chk("mis_read_err", {31'b0, ev}, 32'd0);

        // Back-to-back: write 0x40 then read 0x40 with request held throughout
        acks = 0; first = -1; second = -1; rd2 = '0;
        @(posedge clk); #1;
        mem_write = 1'b1; mem_read = 1'b0; addr = 32'h40; wdata = 32'h55AA55AA;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    first = c;
                    @(posedge clk); #1;
                    mem_write = 1'b0; mem_read = 1'b1;
                end else if (acks == 2) begin
                    second = c; rd2 = rdata;
                    @(posedge clk); #1;
                    mem_read = 1'b0;
                end
            end
        end
        chk("b2b_ack_count", acks, 32'd2);
        chk("b2b_ack_spacing", second - first, 32'd5);
        chk("b2b_read_data", rd2, 32'h55AA55AA);

        // Reset in the 2nd BUSY cycle of a write
        snap = ack_total;
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h30; wdata = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        chk("stall_in_rst", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_ack", ack_total - snap, 32'd0);
        access(1'b1, 1'b0, 32'h30, 32'h0, rv, ns, ev);
        chk("abort_readback", rv, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0, rv, ns, ev);
        chk("rst_cleared_array", rv, 32'h0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words stored (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 3, meaning the number of BUSY cycles per access (1..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port mem_read  input  1  meaning a read request from the EX/MEM stage.
REQ-006 SHALL have port mem_write  input  1  meaning a write request from the EX/MEM stage.
REQ-007 SHALL have port addr  input  32  meaning the byte address (ALU result).
REQ-008 SHALL have port wdata  input  32  meaning the store data.
REQ-009 SHALL have port rdata  output  32  meaning the load data, registered.
REQ-010 SHALL have port stall  output  1  meaning "freeze the pipeline"; the request inputs stay held while it is high.
REQ-011 SHALL have port ack  output  1  meaning access complete, a one-cycle pulse.
REQ-012 SHALL have port err  output  1  meaning a misaligned access, valid with ack (only with the macro).

Function
REQ-013 SHALL implement the states IDLE, BUSY and DONE, plus a 4-bit down-counter.
REQ-014 SHALL, in IDLE with mem_read|mem_write at edge T: capture addr/wdata/op, load counter=LATENCY-1, enter BUSY; stall=1 combinationally during cycle T.
REQ-015 SHALL hold stall=1 in BUSY; the counter decrements each cycle; at counter==0 perform the access and enter DONE.
REQ-016 SHALL, on a read access, register array[index] into rdata on the BUSY->DONE edge; on a write, update array[index] with the captured wdata on that edge.
REQ-017 SHALL, in DONE, drive stall=0 and ack=1 for exactly one cycle, ignore request inputs (the same instruction is still present), then enter IDLE.
REQ-018 SHALL produce a total stall of LATENCY+1 cycles per access; a back-to-back request is accepted in the IDLE cycle after DONE.
REQ-019 SHALL give write priority when mem_read and mem_write are both high: the access is a write and rdata is unchanged.
REQ-020 SHALL compute index = addr[log2(DEPTH)+1:2]; higher address bits are ignored, so out-of-range addresses wrap.
REQ-021 SHALL hold rdata between reads and keep it unchanged by writes.
REQ-022 SHALL keep stall=0 and ack=0 in IDLE with no request.

Reset
REQ-023 SHALL, with rst high at an edge: state=IDLE, counter=0, rdata=0, ack=0, err=0, all array words=0.
REQ-024 SHALL abort any access in progress on reset mid-BUSY: no array write occurs and no ack is produced.
REQ-025 SHALL drive stall=0 during any cycle in which rst is high.

Configuration
REQ-026 SHALL, with DMEM_ALIGN_CHECK_EN defined: an access with addr[1:0]!=0 performs no array write and no rdata update, still takes the full latency, and asserts err=1 together with ack.
REQ-027 SHALL, without DMEM_ALIGN_CHECK_EN: ignore addr[1:0], omit the err port logic and tie err to 0.

Structure
REQ-028 SHALL take the state enum (IDLE/BUSY/DONE) and the default DEPTH/LATENCY constants from the shared package dmem_pkg.
REQ-029 SHALL place storage in one sub-module, dmem_array, providing a synchronous single-port 32-bit RAM with write enable, registered read and a synchronous clear.

Verification
REQ-030 SHALL verify a write then a read: write addr=0x10 wdata=0xDEADBEEF, then read 0x10 -> rdata=0xDEADBEEF at the ack cycle, with stall high for 4 cycles each (LATENCY=3).
REQ-031 SHALL verify wrap: with DEPTH=256, write 0x400+0x8 data=0x12345678, then read 0x8 -> 0x12345678.
REQ-032 SHALL verify simultaneous requests: mem_read=mem_write=1 at addr 0x20 data=0xA5A5A5A5 -> a write occurs, rdata unchanged, and a later read returns 0xA5A5A5A5.
REQ-033 SHALL verify reset mid-BUSY: a write to 0x30 of 0x11111111 with rst pulsed in the 2nd BUSY cycle -> no ack, and a later read of 0x30 returns 0.
REQ-034 SHALL verify misalignment with the macro defined: write addr=0x13 -> ack=1, err=1, and a later read of 0x10 returns its previous value.
REQ-035 SHALL verify back-to-back requests: requests held continuously for two instructions -> exactly two ack pulses 5 cycles apart (LATENCY=3), with no double access in DONE.
